// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the multicycle MIPS datapath.
// Define MULTICYCLE_CU_JUMP_EN to add the j instruction (OP 0x02) and its JUMP state.
module multicycle_control_unit #(
  parameter int MEM_WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic [3:0] state_o,
  output logic       illegal_o
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;
  localparam logic [3:0] wait_n = 4'(MEM_WAIT_CYCLES);
  state_t state, state_n;
  logic [3:0] cnt, funct_alu;
  logic last, r_ok, mem_op, jump_op, illegal;
  assign last = cnt == wait_n;
  assign r_ok = OP == 6'h00 && (Funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
  assign mem_op = OP == 6'h23 || OP == 6'h2B;
`ifdef MULTICYCLE_CU_JUMP_EN
  assign jump_op = OP == 6'h02;
`else
  assign jump_op = 1'b0;
`endif
  assign illegal = !(r_ok || mem_op || OP == 6'h08 || OP == 6'h04 || jump_op);
  assign funct_alu = Funct == 6'h22 ? 4'b0110 :
                     Funct == 6'h24 ? 4'b0000 :
                     Funct == 6'h25 ? 4'b0001 :
                     Funct == 6'h27 ? 4'b1100 :
                     Funct == 6'h2A ? 4'b0111 : 4'b0010;
  // The wait counter restarts on every state change, so it only ever climbs inside FETCH/MEMREAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= state_n != state ? 4'd0 : cnt + 4'd1;
    end
  end
  always_comb begin
    case (state)
      FETCH:    state_n = last ? DECODE : FETCH;
      DECODE:   state_n = r_ok ? EXECUTE : mem_op ? MEMADR : OP == 6'h08 ? ADDIEXEC :
                          OP == 6'h04 ? BRANCH : jump_op ? JUMP : FETCH;
      MEMADR:   state_n = OP == 6'h23 ? MEMREAD : MEMWRITE;
      MEMREAD:  state_n = last ? MEMWB : MEMREAD;
      EXECUTE:  state_n = ALUWB;
      ADDIEXEC: state_n = ADDIWB;
      default:  state_n = FETCH;
    endcase
  end
  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 4'b0010;
    PCSrc      = 2'b00;
    if (!reset) begin
      case (state)
        FETCH: begin
          ALUSrcB = 2'b01;
          IRWrite = last;
          PCWrite = last;
        end
        DECODE:   ALUSrcB = 2'b11;
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMREAD:  IorD = 1'b1;
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEMWRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        EXECUTE: begin
          ALUSrcA    = 1'b1;
          ALUControl = funct_alu;
        end
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUControl = 4'b0110;
          PCSrc      = 2'b01;
          PCWrite    = Zero;
        end
        ADDIEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDIWB:   RegWrite = 1'b1;
`ifdef MULTICYCLE_CU_JUMP_EN
        JUMP: begin
          PCSrc   = 2'b10;
          PCWrite = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end
  assign state_o   = reset ? 4'd0 : state;
  assign illegal_o = !reset && state == DECODE && illegal;
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style FSM that sequences the multicycle MIPS datapath. It decodes `OP`/`Funct` from the instruction register and drives every datapath control strobe: PC/IR write enables, memory and register-file enables, mux selects and ALU operation. It sits beside the datapath inside the core top level, one instance per core. It optionally stretches memory-access states for slow memory.

## Interface
- `MEM_WAIT_CYCLES`, default 0: extra cycles held in FETCH and MEMREAD before the memory data is consumed; range 0–15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; forces FETCH with the wait counter at 0.
- `OP`  in  6  opcode, `Instr[31:26]`.
- `Funct`  in  6  function field, `Instr[5:0]`.
- `Zero`  in  1  ALU zero flag (combinational from the ALU).
- `PCWrite`, `IorD`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`, `ALUSrcA`  out  1 each  datapath strobes/selects.
- `ALUSrcB`  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2.
- `ALUControl`  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- `PCSrc`  out  2  00=ALUResult, 01=ALUOut, 10=jump target.
- `state_o`  out  4  current state code (debug).
- `illegal_o`  out  1  one-cycle pulse on an unsupported OP/Funct.

## Operation
- State codes: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE, 6 EXECUTE, 7 ALUWB, 8 BRANCH, 9 ADDIEXEC, 10 ADDIWB, 11 JUMP.
- Outputs not listed for a state are 0. `ALUControl` defaults to ADD.
- **FETCH:** `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, ADD, `PCSrc`=00. `IRWrite`=`PCWrite`=1 only in the final wait cycle (wait count = `MEM_WAIT_CYCLES`), then go to DECODE.
- **DECODE:** `ALUSrcA`=0, `ALUSrcB`=11, ADD (branch target lands in ALUOut). Next state by `OP`:
  - 0x00 → EXECUTE.
  - 0x23 / 0x2B → MEMADR.
  - 0x08 → ADDIEXEC.
  - 0x04 → BRANCH.
  - 0x02 → JUMP (macro only).
  - any other → FETCH with `illegal_o`=1.
- **R-type funct:** 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT. Any other funct → FETCH from DECODE with `illegal_o`=1; no register write occurs.
- **MEMADR:** `ALUSrcA`=1, `ALUSrcB`=10, ADD. Next: MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD:** `IorD`=1, held 1+`MEM_WAIT_CYCLES` cycles, then MEMWB.
- **MEMWB:** `RegDst`=0, `MemtoReg`=1, `RegWrite`=1, then FETCH.
- **MEMWRITE:** `IorD`=1, `MemWrite`=1 for exactly one cycle, then FETCH.
- **EXECUTE:** `ALUSrcA`=1, `ALUSrcB`=00, funct-decoded op, then ALUWB.
- **ALUWB:** `RegDst`=1, `MemtoReg`=0, `RegWrite`=1, then FETCH.
- **BRANCH:** `ALUSrcA`=1, `ALUSrcB`=00, SUB, `PCSrc`=01, `PCWrite`=`Zero` (combinational), then FETCH.
- **ADDIEXEC:** `ALUSrcA`=1, `ALUSrcB`=10, ADD, then ADDIWB.
- **ADDIWB:** `RegDst`=0, `MemtoReg`=0, `RegWrite`=1, then FETCH.
- Wait counter is 4 bits. It clears on every state entry and never wraps; with `MEM_WAIT_CYCLES`=0 it is unused.

## Timing
- State register and wait counter update on the rising edge of `clk`. All outputs are decoded from the registered state; only `PCWrite` in BRANCH also depends on `Zero`.
- While `reset`=1, every write enable (`PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`) and `illegal_o` are gated to 0. `state_o`=0, all selects are 0 and `ALUControl`=ADD.
- The first fetch write happens in the first cycle after reset deasserts (N=0). Reset asserted mid-instruction aborts it; no further write enable is asserted.
- `OP`/`Funct` are sampled only in DECODE; they are stable because `IRWrite` is low outside FETCH.
- Cycles per instruction with N=`MEM_WAIT_CYCLES`:
  - lw: 5+2N
  - sw, R-type, addi: 4+N
  - beq, j: 3+N
  - illegal: 2+N

## Configuration
- `MULTICYCLE_CU_JUMP_EN` defined: OP 0x02 → JUMP. JUMP drives `PCSrc`=10 and `PCWrite`=1 for one cycle, then FETCH.
- Not defined: JUMP state is absent. OP 0x02 is illegal (pulse `illegal_o`, return to FETCH). `PCSrc`[1] is tied to 0.

## Test plan
- Reset, then `OP`=0x00, `Funct`=0x20, N=0:
  - states 0→1→6→7→0;
  - `IRWrite`/`PCWrite` high in cycle 1 only;
  - `RegWrite`=1 with `RegDst`=1 in cycle 4;
  - `ALUControl`=0010 in EXECUTE.
- lw (`OP`=0x23) with N=2:
  - FETCH lasts 3 cycles, with `IRWrite` only in the 3rd;
  - MEMREAD lasts 3 cycles with `IorD`=1;
  - MEMWB has `MemtoReg`=1; total 9 cycles.
- beq (`OP`=0x04):
  - `Zero`=1 → `PCWrite`=1, `PCSrc`=01, `ALUControl`=0110 in BRANCH;
  - `Zero`=0 → `PCWrite`=0; 3 cycles either way.
- sw (`OP`=0x2B): `MemWrite`=1 for exactly one cycle with `IorD`=1; no `RegWrite`; total 4 cycles.
- `OP`=0x3F, and R-type `Funct`=0x01: `illegal_o` pulses one cycle in DECODE, return to FETCH, no write enable asserted.
- Assert `reset` in MEMREAD: next cycle `state_o`=0 with all enables 0. With the macro, `OP`=0x02 yields `PCSrc`=10 and `PCWrite`=1 in state 11.
